// File: rtl/mem_latency_nport_pkg.sv
// Shared constants and types for the N-port latency test memory.
package mem_latency_pkg;
    localparam logic MEM_READ    = 1'b0;
    localparam logic MEM_WRITE   = 1'b1;
    localparam int   MAX_PORTS   = 8;
    localparam int   MAX_LATENCY = 15;

    typedef logic [31:0] mem_word_t;
endpackage

// File: rtl/mem_latency_nport_port_delay.sv
// Per-port request delay tracker: counts LATENCY wait cycles for a held
// request, then flags the port eligible until it is granted or dropped.
module mem_port_delay
    import mem_latency_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_val,
    input  logic i_grant,
    output logic o_elig,
    output logic o_done,
    output logic o_wait
);
    // The first wait cycle is the one the request appears in, so the
    // counter is loaded with LATENCY-1 to give exactly LATENCY stalls.
    localparam logic [3:0] LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [3:0] r_cnt;
    logic       r_pend;
    logic       w_elig;
    logic       w_done;

    // Eligibility, completion and stall; everything is forced quiet in reset.
    always_comb begin
        w_elig = 1'b0;
        if (!rst && i_val)
            w_elig = r_pend ? (r_cnt == 4'd0) : (LATENCY == 0);
        w_done = w_elig && i_grant;
        o_elig = w_elig;
        o_done = w_done;
        o_wait = !rst && i_val && !w_done;
    end

    // Counter/pending state: cleared on reset, drop or completion; a losing
    // eligible port stays pending with the counter parked at zero.
    always_ff @(posedge clk) begin
        if (rst || !i_val || w_done) begin
            r_cnt  <= 4'd0;
            r_pend <= 1'b0;
        end else if (!r_pend) begin
            r_cnt  <= LOAD;
            r_pend <= 1'b1;
        end else if (r_cnt != 4'd0) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end
endmodule

// File: rtl/mem_latency_nport.sv
// N-port word memory with per-port request latency, optional single-bank
// round-robin completion, and a backdoor write port for bench loading.
module mem_latency_nport
    import mem_latency_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int ADDR_BITS   = 10,
    parameter int LATENCY     = 0,
    parameter int SINGLE_BANK = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0]     mem_val,
    output logic [NPORTS-1:0]     mem_wait,
    input  logic [NPORTS-1:0]     mem_type,
    input  logic [32*NPORTS-1:0]  mem_addr,
    input  logic [32*NPORTS-1:0]  mem_wdata,
    output logic [32*NPORTS-1:0]  mem_rdata,
    input  logic                  bd_wen,
    input  logic [31:0]           bd_addr,
    input  logic [31:0]           bd_wdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    mem_word_t            r_mem [DEPTH];
    logic [2:0]           r_ptr;
    logic [NPORTS-1:0]    w_elig;
    logic [NPORTS-1:0]    w_grant;
    logic [NPORTS-1:0]    w_done;
    logic [ADDR_BITS-1:0] w_idx [NPORTS];
    logic [ADDR_BITS-1:0] w_bd_idx;
    int                   w_best_p;
    int                   w_best_d;
    int                   w_d;
    logic                 w_unused;

    // Byte address -> word index; low and high bits are ignored so
    // out-of-range addresses alias into the array.
    assign w_bd_idx = bd_addr[ADDR_BITS+1:2];
    assign w_unused = ^{mem_addr, bd_addr};

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign w_idx[p] = mem_addr[32*p+2 +: ADDR_BITS];

        mem_port_delay #(.LATENCY(LATENCY)) u_delay (
            .clk     (clk),
            .rst     (rst),
            .i_val   (mem_val[p]),
            .i_grant (w_grant[p]),
            .o_elig  (w_elig[p]),
            .o_done  (w_done[p]),
            .o_wait  (mem_wait[p])
        );
    end

    // Round-robin pick: the eligible port with the smallest upward distance
    // from the pointer wins; without single-bank every eligible port wins.
    always_comb begin
        w_best_p = 0;
        w_best_d = NPORTS;
        w_d      = 0;
        w_grant  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_d = p - int'(r_ptr);
            if (w_d < 0)
                w_d = w_d + NPORTS;
            if (w_elig[p] && w_d < w_best_d) begin
                w_best_d = w_d;
                w_best_p = p;
            end
        end
        for (int p = 0; p < NPORTS; p++) begin
            if (SINGLE_BANK == 0)
                w_grant[p] = w_elig[p];
            else
                w_grant[p] = (w_best_d < NPORTS) && (w_best_p == p);
        end
    end

    // Pointer moves past the granted port; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 3'd0;
        else if (SINGLE_BANK != 0 && w_best_d < NPORTS)
            r_ptr <= 3'((w_best_p + 1 >= NPORTS) ? 0 : w_best_p + 1);
    end

    // Read data only on a completing read, otherwise zero; reads see the
    // array before this cycle's writes land.
    always_comb begin
        mem_rdata = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_done[p] && mem_type[p] == MEM_READ)
                mem_rdata[32*p +: 32] = r_mem[w_idx[p]];
        end
    end

    // Array update: port writes in ascending order so the highest port wins,
    // then the backdoor on top. Contents survive reset; writes do not happen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (w_done[p] && mem_type[p] == MEM_WRITE)
                    r_mem[w_idx[p]] <= mem_wdata[32*p +: 32];
            end
            if (bd_wen)
                r_mem[w_bd_idx] <= bd_wdata;
        end
    end
endmodule

// File: tb/tb_mem_latency_nport.sv
// Randomised bench: four memory configurations driven side by side and
// checked every cycle against a request-age / array reference model.
module tb_mem_latency_nport;
    localparam int NI = 4;
    localparam int NP = 3;
    localparam int LAT_T [NI] = '{0, 3, 0, 2};
    localparam int SB_T  [NI] = '{0, 0, 1, 1};
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    val  [NI];
    logic [NP-1:0]    typ  [NI];
    logic [NP-1:0]    wt   [NI];
    logic [32*NP-1:0] addr [NI];
    logic [32*NP-1:0] wdat [NI];
    logic [32*NP-1:0] rdat [NI];
    logic             bdw  [NI];
    logic [31:0]      bda  [NI];
    logic [31:0]      bdd  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_latency_nport #(
            .NPORTS(NP), .ADDR_BITS(10), .LATENCY(LAT_T[g]), .SINGLE_BANK(SB_T[g])
        ) u_dut (
            .clk(clk), .rst(rst),
            .mem_val(val[g]), .mem_wait(wt[g]), .mem_type(typ[g]),
            .mem_addr(addr[g]), .mem_wdata(wdat[g]), .mem_rdata(rdat[g]),
            .bd_wen(bdw[g]), .bd_addr(bda[g]), .bd_wdata(bdd[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: array image, cycles each request has been held
    // without completing, whether a request is in flight, arbitration pointer.
    logic [31:0] mm     [NI][1024];
    int          held   [NI][NP];
    bit          inprog [NI][NP];
    int          ptr    [NI];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Random byte address that maps to word w (0..7): random high and low
    // bits exercise aliasing above the 10-bit index.
    function automatic logic [31:0] rnd_addr(input int w);
        logic [31:0] r;
        r = $urandom();
        r[11:2] = 10'(w);
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    initial begin
        int          rcnt;
        bit          elig [NP];
        bit          done [NP];
        int          gq;
        int          q;
        logic [31:0] a;
        logic [31:0] exp_r;
        logic        exp_w;

        rcnt = 0;
        for (int i = 0; i < NI; i++) begin
            val[i] = '0; typ[i] = '0; addr[i] = '0; wdat[i] = '0;
            bdw[i] = 1'b0; bda[i] = '0; bdd[i] = '0;
            ptr[i] = 0;
            for (int p = 0; p < NP; p++) begin
                held[i][p] = 0;
                inprog[i][p] = 1'b0;
            end
        end

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // Phases: 3 reset cycles with live requests, 8 backdoor loads,
            // then random traffic with occasional short resets.
            if (c < 3)
                rst = 1'b1;
            else if (c < 11)
                rst = 1'b0;
            else begin
                if (rcnt == 0 && $urandom_range(0, 149) == 0)
                    rcnt = $urandom_range(1, 3);
                rst = (rcnt > 0);
                if (rcnt > 0)
                    rcnt--;
            end

            for (int i = 0; i < NI; i++) begin
                if (c >= 3 && c < 11) begin
                    val[i] = '0;
                    bdw[i] = 1'b1;
                    bda[i] = rnd_addr(c - 3);
                    bdd[i] = $urandom();
                end else begin
                    bdw[i] = ($urandom_range(0, 7) == 0);
                    bda[i] = rnd_addr($urandom_range(0, 7));
                    bdd[i] = $urandom();
                    if (!rst || c < 3) begin
                        for (int p = 0; p < NP; p++) begin
                            if (inprog[i][p] && c >= 3) begin
                                if ($urandom_range(0, 11) == 0)
                                    val[i][p] = 1'b0;
                            end else begin
                                val[i][p] = ($urandom_range(0, 3) != 0);
                                typ[i][p] = 1'($urandom_range(0, 1));
                                addr[i][32*p +: 32] = rnd_addr($urandom_range(0, 7));
                                wdat[i][32*p +: 32] = $urandom();
                            end
                        end
                    end
                end
            end

            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                for (int p = 0; p < NP; p++) begin
                    elig[p] = !rst && val[i][p] && (held[i][p] >= LAT_T[i]);
                    done[p] = 1'b0;
                end
                gq = -1;
                if (SB_T[i] == 0) begin
                    for (int p = 0; p < NP; p++)
                        done[p] = elig[p];
                end else begin
                    for (int k = 0; k < NP; k++) begin
                        q = (ptr[i] + k) % NP;
                        if (gq < 0 && elig[q]) begin
                            gq = q;
                            done[q] = 1'b1;
                        end
                    end
                end

                for (int p = 0; p < NP; p++) begin
                    a = addr[i][32*p +: 32];
                    exp_w = !rst && val[i][p] && !done[p];
                    exp_r = (done[p] && !typ[i][p]) ? mm[i][widx(a)] : 32'h0;
                    chk($sformatf("d%0d.p%0d.wait@%0d", i, p, c), {31'b0, wt[i][p]}, {31'b0, exp_w});
                    chk($sformatf("d%0d.p%0d.rdata@%0d", i, p, c), rdat[i][32*p +: 32], exp_r);
                end

                if (rst) begin
                    ptr[i] = 0;
                    for (int p = 0; p < NP; p++) begin
                        held[i][p] = 0;
                        inprog[i][p] = val[i][p];
                    end
                end else begin
                    for (int p = 0; p < NP; p++)
                        if (done[p] && typ[i][p])
                            mm[i][widx(addr[i][32*p +: 32])] = wdat[i][32*p +: 32];
                    if (bdw[i])
                        mm[i][widx(bda[i])] = bdd[i];
                    for (int p = 0; p < NP; p++) begin
                        if (done[p] || !val[i][p]) begin
                            held[i][p] = 0;
                            inprog[i][p] = 1'b0;
                        end else begin
                            held[i][p]++;
                            inprog[i][p] = 1'b1;
                        end
                    end
                    if (gq >= 0)
                        ptr[i] = (gq + 1) % NP;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
